fb_plot_writer: RTL and testbench
=================================

FB_PLOT_WRITER -- requirements
Module: fb_plot_writer

Interface
REQ-001 Parameter W, default 160: frame width in pixels.
REQ-002 Parameter H, default 120: frame height in pixels.
REQ-003 Parameter DEPTH, default 8: FIFO entries, a power of 2 no smaller than 2.
REQ-004 clock  input  1  system clock; every register is rising-edge triggered.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 x_s  input  8  plot x coordinate, from the edge stream path.
REQ-007 y_s  input  7  plot y coordinate.
REQ-008 colour_s  input  24  plot colour in RGB888.
REQ-009 plot_s  input  1  plot strobe; x_s, y_s and colour_s are valid when it is high.
REQ-010 clear  input  1  synchronous clear of the overflow flag and drop counter.
REQ-011 wr_addr  output  15  framebuffer write address, y*W+x.
REQ-012 wr_data  output  24  framebuffer write data.
REQ-013 wr_en  output  1  write request; high when the FIFO is not empty.
REQ-014 wr_grant  input  1  memory accepts the write in any cycle where wr_en && wr_grant.
REQ-015 frame_done  output  1  one-cycle pulse when the last pixel of a frame is written.
REQ-016 frame_count  output  8  count of completed frames, wraps from 255 to 0.
REQ-017 overflow  output  1  sticky flag: a pixel was dropped.
REQ-018 drop_count  output  16  count of dropped pixels, saturates at 16'hFFFF.
REQ-019 fifo_level  output  4  registered FIFO occupancy, 0..DEPTH.

Function
REQ-020 FSM states: SYNC (the reset state) and RUN.
REQ-021 In SYNC: every plot is discarded and no counter changes, except the plot described in REQ-022.
REQ-022 A plot with x_s==0 and y_s==0 in SYNC moves the FSM to RUN and is pushed in the same cycle.
REQ-023 In RUN: a plot with x_s>=W or y_s>=H is discarded silently and is not counted as dropped.
REQ-024 In RUN: an in-range plot is pushed when fifo_level<DEPTH.
REQ-025 In RUN: an in-range plot with fifo_level==DEPTH is dropped, overflow is set, and drop_count increments with saturation.
REQ-026 Full is judged on the registered level only: a push while full is dropped even if a pop occurs in the same cycle.
REQ-027 Each pushed entry stores {addr, colour}; addr=y*W+x is computed combinationally at push time, 15 bits, without overflow for the default parameters (max 19199).
REQ-028 The FIFO is first-word-fall-through: wr_addr and wr_data present the head entry while wr_en=1.
REQ-029 Push-to-wr_en latency is exactly 1 cycle when the FIFO is empty: a push at edge N gives wr_en=1 after edge N.
REQ-030 A pop occurs on the edge where wr_en && wr_grant; no pop occurs when the FIFO is empty.
REQ-031 Simultaneous push and pop with 0<level<DEPTH leaves fifo_level unchanged and preserves order.
REQ-032 Read and write pointers wrap modulo DEPTH.
REQ-033 When the popped entry has addr==W*H-1: frame_done pulses for the cycle after that edge, and frame_count increments.
REQ-034 clear=1 zeroes overflow and drop_count on the next edge.
REQ-035 clear has priority over a simultaneous drop: the result is overflow=0 and drop_count=0.
REQ-036 clear does not affect the FSM, the FIFO or frame_count.
REQ-037 wr_en, wr_addr and wr_data change only on clock edges; they are driven from registers or from FIFO storage selected by a registered pointer.

Reset
REQ-038 resetn low asynchronously forces the FSM to SYNC.
REQ-039 resetn low asynchronously forces the pointers and fifo_level to 0, and wr_en to 0.
REQ-040 resetn low asynchronously forces frame_done=0, frame_count=0, overflow=0 and drop_count=0.
REQ-041 wr_addr and wr_data read 0 during reset.
REQ-042 Reset asserted mid-frame discards all buffered entries; no write is issued after reset until a new (0,0) plot arrives.
REQ-043 Memory contents are outside this block and are not cleared.

Verification
REQ-044 Test: after reset, plots (5,3) then (0,0) colour 24'h123456, wr_grant=1 -> (5,3) ignored; one write with wr_addr=0 and wr_data=24'h123456 appears 1 cycle after the (0,0) plot.
REQ-045 Test: full raster 160x120 with one plot per cycle and wr_grant=1 -> 19200 writes in raster order; frame_done pulses once after addr 19199; frame_count=1; drop_count=0.
REQ-046 Test: in RUN with wr_grant=0, 10 in-range plots -> 8 held (fifo_level=8), drop_count=2, overflow=1; then wr_grant=1 -> the first 8 pixels are written in order.
REQ-047 Test: plot (160,0) and plot (0,120) in RUN -> no push, no drop, fifo_level unchanged.
REQ-048 Test: drop and clear in the same cycle -> drop_count=0 and overflow=0 next cycle; a later drop gives drop_count=1.
REQ-049 Test: resetn pulsed low with fifo_level=5 -> level=0, wr_en=0 immediately; subsequent plots ignored until (0,0).

Source files
------------

// File: rtl/fb_plot_writer.sv
// Buffers (x,y,colour) plot strobes into a small FWFT FIFO of framebuffer writes,
// aligning to the first (0,0) pixel and tracking frame completion and dropped pixels.
module fb_plot_writer #(
  parameter int W     = 160,
  parameter int H     = 120,
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [7:0]  x_s,
  input  logic [6:0]  y_s,
  input  logic [23:0] colour_s,
  input  logic        plot_s,
  input  logic        clear,
  output logic [14:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        wr_en,
  input  logic        wr_grant,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic        overflow,
  output logic [15:0] drop_count,
  output logic [3:0]  fifo_level
);

  localparam int          PW         = $clog2(DEPTH);
  localparam logic [8:0]  W_LIM      = 9'(W);
  localparam logic [7:0]  H_LIM      = 8'(H);
  localparam logic [14:0] LAST_ADDR  = 15'(W * H - 1);
  localparam logic [3:0]  FULL_LEVEL = 4'(DEPTH);

  typedef enum logic {SYNC, RUN} state_t;

  state_t          state_reg, state_next;
  logic [38:0]     entry_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [3:0]      level_reg, level_next;
  logic            wr_en_reg;
  logic            frame_done_reg;
  logic [7:0]      frame_count_reg;
  logic            overflow_reg;
  logic [15:0]     drop_count_reg;

  logic            in_range, at_origin, full;
  logic            push, drop, pop;
  logic [14:0]     plot_addr;
  logic [38:0]     head;

  assign in_range  = ({1'b0, x_s} < W_LIM) && ({1'b0, y_s} < H_LIM);
  assign at_origin = (x_s == 8'd0) && (y_s == 7'd0);
  assign full      = (level_reg == FULL_LEVEL);
  assign plot_addr = 15'(y_s) * 15'(W) + 15'(x_s);
  assign pop       = wr_en_reg && wr_grant;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_reg <= SYNC;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      SYNC: begin
        // Only the frame origin may start a stream; everything before it is noise.
        if (plot_s && at_origin && !full) begin
          push       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (plot_s && in_range) begin
          if (full) drop = 1'b1;
          else      push = 1'b1;
        end
      end
      default: state_next = SYNC;
    endcase
  end

  // Entry storage is deliberately left unreset; only pointers define validity.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clock) begin
        if (push && (wr_ptr_reg == PW'(gi)))
          entry_mem[gi] <= {plot_addr, colour_s};
      end
    end
  endgenerate

  assign head       = entry_mem[rd_ptr_reg];
  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_en_reg ? head[38:24] : 15'd0;
  assign wr_data    = wr_en_reg ? head[23:0]  : 24'd0;
  assign fifo_level = level_reg;
  assign level_next = level_reg + {3'b000, push} - {3'b000, pop};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= 4'd0;
      wr_en_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      level_reg <= level_next;
      wr_en_reg <= (level_next != 4'd0);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frame_done_reg  <= 1'b0;
      frame_count_reg <= 8'd0;
    end else begin
      frame_done_reg <= pop && (head[38:24] == LAST_ADDR);
      if (pop && (head[38:24] == LAST_ADDR))
        frame_count_reg <= frame_count_reg + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= 16'd0;
    end else if (clear) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= 16'd0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (drop_count_reg != 16'hFFFF)
        drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;
  assign overflow    = overflow_reg;
  assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_fb_plot_writer.sv
// Directed bench for fb_plot_writer: a queue-based model of the write stream is
// compared every cycle, with literal expectations pinning key scenarios.
module tb_fb_plot_writer;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        resetn;
  logic [7:0]  x_s;
  logic [6:0]  y_s;
  logic [23:0] colour_s;
  logic        plot_s;
  logic        clear;
  logic [14:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_en;
  logic        wr_grant;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        overflow;
  logic [15:0] drop_count;
  logic [3:0]  fifo_level;

  fb_plot_writer #(.W(W), .H(H), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn),
    .x_s(x_s), .y_s(y_s), .colour_s(colour_s), .plot_s(plot_s), .clear(clear),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_grant(wr_grant),
    .frame_done(frame_done), .frame_count(frame_count), .overflow(overflow),
    .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  // Model: pending writes as a queue of {addr, colour}, plus the status the spec defines.
  logic [38:0] m_q[$];
  bit          m_run;
  logic [15:0] m_drops;
  bit          m_ovf;
  logic [7:0]  m_frames;
  bit          m_done;
  int          m_pops;
  int          m_sz;
  int          m_addr;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_q.delete();
      m_run    = 0;
      m_drops  = 16'd0;
      m_ovf    = 0;
      m_frames = 8'd0;
      m_done   = 0;
    end else begin
      m_sz   = m_q.size();
      m_done = 0;
      if (m_sz > 0 && wr_grant) begin
        m_addr = int'(m_q[0][38:24]);
        void'(m_q.pop_front());
        m_pops++;
        if (m_addr == W * H - 1) begin
          m_done   = 1;
          m_frames = m_frames + 8'd1;
        end
      end
      if (plot_s) begin
        m_addr = int'(y_s) * W + int'(x_s);
        if (!m_run) begin
          if (x_s == 0 && y_s == 0) begin
            m_run = 1;
            m_q.push_back({15'(m_addr), colour_s});
          end
        end else if (int'(x_s) < W && int'(y_s) < H) begin
          if (m_sz == DEPTH) begin
            m_ovf = 1;
            if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
          end else begin
            m_q.push_back({15'(m_addr), colour_s});
          end
        end
      end
      if (clear) begin
        m_drops = 16'd0;
        m_ovf   = 0;
      end
    end
  end

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic cyc();
    @(negedge clock);
    if (resetn) begin
      chk("wr_en", 64'(wr_en), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("wr_addr", 64'(wr_addr), 64'(m_q[0][38:24]));
        chk("wr_data", 64'(wr_data), 64'(m_q[0][23:0]));
      end
      chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
      chk("drop_count", 64'(drop_count), 64'(m_drops));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("frame_count", 64'(frame_count), 64'(m_frames));
      chk("frame_done", 64'(frame_done), 64'(m_done));
      if (frame_done) done_seen++;
    end
  endtask

  task automatic plot(input int x, input int y, input logic [23:0] c);
    plot_s   = 1'b1;
    x_s      = 8'(x);
    y_s      = 7'(y);
    colour_s = c;
    cyc();
    plot_s   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  int done0;
  int pops0;

  initial begin
    resetn   = 1'b0;
    x_s      = 8'd0;
    y_s      = 7'd0;
    colour_s = 24'd0;
    plot_s   = 1'b0;
    clear    = 1'b0;
    wr_grant = 1'b1;
    cyc();
    cyc();
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_frames", 64'(frame_count), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    resetn = 1'b1;
    cyc();

    $display("test sync: plot (5,3) then (0,0)");
    plot(5, 3, 24'hAAAAAA);
    chk("sync_ignored_level", 64'(fifo_level), 64'd0);
    plot(0, 0, 24'h123456);
    chk("sync_wr_en", 64'(wr_en), 64'd1);
    chk("sync_wr_addr", 64'(wr_addr), 64'd0);
    chk("sync_wr_data", 64'(wr_data), 64'h123456);
    idle(3);

    $display("test raster: %0dx%0d frame", W, H);
    done0 = done_seen;
    pops0 = m_pops;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        plot(x, y, 24'((y << 8) ^ x ^ 24'h5A0000));
    idle(5);
    chk("raster_writes", 64'(m_pops - pops0), 64'd19200);
    chk("raster_done_pulses", 64'(done_seen - done0), 64'd1);
    chk("raster_frame_count", 64'(frame_count), 64'd1);
    chk("raster_drops", 64'(drop_count), 64'd0);

    $display("test overflow: 10 plots with wr_grant=0");
    wr_grant = 1'b0;
    for (int i = 0; i < 10; i++) plot(i, 1, 24'(24'h010000 + i));
    chk("ovf_level", 64'(fifo_level), 64'd8);
    chk("ovf_drops", 64'(drop_count), 64'd2);
    chk("ovf_flag", 64'(overflow), 64'd1);
    wr_grant = 1'b1;
    chk("ovf_head_addr", 64'(wr_addr), 64'd160);
    chk("ovf_head_data", 64'(wr_data), 64'h010000);
    idle(10);
    chk("ovf_drained", 64'(fifo_level), 64'd0);

    $display("test out of range: (160,0) and (0,120)");
    wr_grant = 1'b0;
    plot(160, 0, 24'hFFFFFF);
    plot(0, 120, 24'hFFFFFF);
    chk("oor_level", 64'(fifo_level), 64'd0);
    chk("oor_drops", 64'(drop_count), 64'd2);

    $display("test clear vs drop");
    for (int i = 0; i < DEPTH; i++) plot(i, 2, 24'(24'h020000 + i));
    clear = 1'b1;
    plot(20, 2, 24'h0BAD00);
    clear = 1'b0;
    chk("clr_drops", 64'(drop_count), 64'd0);
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_level", 64'(fifo_level), 64'd8);
    plot(21, 2, 24'h0BAD01);
    chk("clr_later_drop", 64'(drop_count), 64'd1);
    wr_grant = 1'b1;
    idle(10);

    $display("test async reset with 5 buffered");
    wr_grant = 1'b0;
    for (int i = 0; i < 5; i++) plot(i, 3, 24'(24'h030000 + i));
    chk("prerst_level", 64'(fifo_level), 64'd5);
    #2 resetn = 1'b0;
    #1;
    chk("arst_wr_en", 64'(wr_en), 64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    chk("arst_wr_addr", 64'(wr_addr), 64'd0);
    chk("arst_frames", 64'(frame_count), 64'd0);
    chk("arst_drops", 64'(drop_count), 64'd0);
    cyc();
    cyc();
    resetn   = 1'b1;
    wr_grant = 1'b1;
    cyc();
    plot(3, 3, 24'h333333);
    chk("post_rst_ignored", 64'(wr_en), 64'd0);
    plot(0, 0, 24'h0ABCDE);
    chk("post_rst_wr_en", 64'(wr_en), 64'd1);
    chk("post_rst_addr", 64'(wr_addr), 64'd0);
    chk("post_rst_data", 64'(wr_data), 64'h0ABCDE);
    idle(3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
